// File: rtl/sdio_response_source.sv
// Byte source for the SDIO slave response path: a producer fills a byte FIFO,
// and each data4 write transaction streams a counted number of bytes to the slave.
module sdio_response_source #(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [7:0]  PAD_BYTE   = 8'hFF,
  parameter int          COUNT_W    = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fill_strobe,
  input  logic [7:0]            fill_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  fifo_full,
  input  logic                  write_data4_strobe,
  input  logic [COUNT_W-1:0]    data4_count,
  output logic                  response_start_write,
  input  logic                  response_data_req,
  output logic                  response_data_strobe,
  output logic [7:0]            response_data,
  output logic                  response_data_empty,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overflow,
  input  logic                  clear_flags,
  output logic [1:0]            debug_state
);

  // Handshake: the slave raises response_data_req for one cycle per byte it
  // wants; exactly one cycle later this block answers with a one-cycle
  // response_data_strobe carrying the byte, or with response_data_empty once
  // the transaction count is used up. There is no back-pressure on the slave.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t               state;
  state_t               state_next;
  logic [COUNT_W-1:0]   remaining;
  logic [COUNT_W-1:0]   remaining_next;
  logic                 serve;
  logic                 mark_empty;

  logic [7:0]            mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic                  pop;
  logic                  pad;
  logic                  push;
  logic                  drop;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // A new transaction strobe wins over everything, including a request
  // arriving in the same cycle.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    serve          = 1'b0;
    mark_empty     = 1'b0;
    if (write_data4_strobe) begin
      state_next     = ARM;
      remaining_next = data4_count;
    end else begin
      case (state)
        IDLE: ;
        ARM: state_next = (remaining != '0) ? STREAM : DONE;
        STREAM: begin
          if (response_data_req && remaining != '0) begin
            serve          = 1'b1;
            remaining_next = remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) state_next = DONE;
          end
        end
        DONE: if (response_data_req) mark_empty = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  assign fifo_full = (fifo_level == FULL_LEVEL);
  assign pop       = serve && (fifo_level != '0);
  assign pad       = serve && (fifo_level == '0);
  // When full, a same-cycle pop frees the slot the push needs.
  assign push      = fill_strobe && (!fifo_full || pop);
  assign drop      = fill_strobe && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= fill_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr               <= '0;
      wr_ptr               <= '0;
      fifo_level           <= '0;
      response_data        <= '0;
      response_data_strobe <= 1'b0;
      response_data_empty  <= 1'b0;
      underrun             <= 1'b0;
      overflow             <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      response_data_strobe <= serve;
      if (pop)      response_data <= mem[rd_ptr];
      else if (pad) response_data <= PAD_BYTE;

      if (write_data4_strobe) response_data_empty <= 1'b0;
      else if (mark_empty)    response_data_empty <= 1'b1;

      // Set has priority over clear so no event is lost.
      underrun <= pad  | (underrun & ~clear_flags);
      overflow <= drop | (overflow & ~clear_flags);
    end
  end

  assign response_start_write = (state == ARM);
  assign busy                 = (state != IDLE);
  assign debug_state          = state;

endmodule
